// File: rtl/ysyx_24080014_wbu.sv
// Writeback unit: single holding stage between LSU/EXU results and the GPR write port,
// with load-data alignment, a commit handshake, and a per-register outstanding-write scoreboard.
`timescale 1ns/1ps

module ysyx_24080014_wbu #(
    parameter int unsigned  XLEN  = 32,
    parameter int unsigned  NREG  = 32,
    parameter int unsigned  CNT_W = 2,
    localparam int unsigned RW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_wen,
    input  logic [RW-1:0]   in_rd,
    input  logic [XLEN-1:0] in_data,
    input  logic            in_is_load,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,

    output logic            commit_valid,
    input  logic            commit_ready,
    output logic [XLEN-1:0] commit_pc,

    output logic            gpr_wen,
    output logic [RW-1:0]   gpr_rd,
    output logic [XLEN-1:0] gpr_wdata,

    input  logic            sb_set,
    input  logic [RW-1:0]   sb_set_rd,
    output logic            sb_set_ready,
    input  logic [RW-1:0]   rs1_q,
    input  logic [RW-1:0]   rs2_q,
    output logic            rs1_busy,
    output logic            rs2_busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic            wb_valid_q, wb_valid_d;
    logic [XLEN-1:0] wb_pc_q,    wb_pc_d;
    logic            wb_wen_q,   wb_wen_d;
    logic [RW-1:0]   wb_rd_q,    wb_rd_d;
    logic [XLEN-1:0] wb_data_q,  wb_data_d;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];

    logic            accept;
    logic            fire;
    logic            inc;
    logic            dec;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] load_data;

    // Handshake; reset masks the held entry so nothing retires or writes while rst is high
    assign in_ready     = rst | ~wb_valid_q | commit_ready;
    assign commit_valid = wb_valid_q & ~rst;
    assign fire         = commit_valid & commit_ready;
    assign accept       = in_valid & in_ready & ~rst;

    assign dec          = fire & wb_wen_q & (wb_rd_q != '0);
    assign gpr_wen      = dec;
    assign commit_pc    = wb_pc_q;
    assign gpr_rd       = wb_rd_q;
    assign gpr_wdata    = wb_data_q;

    // Byte/half selection by address offset; a half at offset 3 only has one real byte
    always_comb begin
        ld_byte = in_data[7:0];
        ld_half = in_data[15:0];
        case (in_addr_lo)
            2'd0: begin
                ld_byte = in_data[7:0];
                ld_half = in_data[15:0];
            end
            2'd1: begin
                ld_byte = in_data[15:8];
                ld_half = in_data[23:8];
            end
            2'd2: begin
                ld_byte = in_data[23:16];
                ld_half = in_data[31:16];
            end
            default: begin
                ld_byte = in_data[31:24];
                ld_half = {8'h00, in_data[31:24]};
            end
        endcase
    end

    // Load extension; non-loads, lw and unknown funct3 pass the word through
    always_comb begin
        load_data = in_data;
        if (in_is_load) begin
            case (in_funct3)
                3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
                3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
                3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
                3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
                default: load_data = in_data;
            endcase
        end
    end

    // Holding stage next state
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_pc_d    = wb_pc_q;
        wb_wen_d   = wb_wen_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        if (accept) begin
            wb_valid_d = 1'b1;
            wb_pc_d    = in_pc;
            wb_wen_d   = in_wen;
            wb_rd_d    = in_rd;
            wb_data_d  = load_data;
        end else if (fire) begin
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_pc_q    <= '0;
            wb_wen_q   <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_pc_q    <= wb_pc_d;
            wb_wen_q   <= wb_wen_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // A saturated counter can still take a set when the same register retires this cycle
    assign sb_set_ready = rst
                        | (cnt_q[sb_set_rd] != CNT_MAX)
                        | (dec & (wb_rd_q == sb_set_rd))
                        | (sb_set_rd == '0);
    assign inc          = sb_set & sb_set_ready & ~rst & (sb_set_rd != '0);

    assign rs1_busy     = ~rst & (cnt_q[rs1_q] != '0);
    assign rs2_busy     = ~rst & (cnt_q[rs2_q] != '0);

    // Scoreboard counters; entry 0 stays zero, underflow holds at zero
    always_comb begin
        logic inc_r;
        logic dec_r;
        for (int unsigned r = 0; r < NREG; r++) begin
            inc_r    = inc & (sb_set_rd == RW'(r));
            dec_r    = dec & (wb_rd_q == RW'(r));
            cnt_d[r] = cnt_q[r];
            if (r == 0) begin
                cnt_d[r] = '0;
            end else if (inc_r && !dec_r) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec_r && !inc_r && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned r = 0; r < NREG; r++) begin
            if (rst) begin
                cnt_q[r] <= '0;
            end else begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule
